hack_ram_arbiter: RTL and testbench

Shares the single-port Hack data RAM between the Hack CPU and a secondary bus master, such as a debug monitor or DMA loader, on the system clock. The CPU has fixed priority. The secondary port uses a valid/ready handshake and is granted the RAM on cycles when the CPU is not accessing memory. An optional starvation guard stalls the CPU for one cycle, through a registered hold output that drives the CPU clock enable, so the secondary port cannot starve. The block sits between the memory/I/O bridge's RAM-side signals and `hack_ram`.

---
 rtl/hack_arb_pkg.sv | 12 +
 rtl/arb_starve_timer.sv | 43 ++++
 rtl/hack_ram_arbiter.sv | 103 ++++++++++
 tb/tb_hack_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_arb_pkg.sv
// Shared types and constants for the Hack RAM arbiter.
package hack_arb_pkg;

  localparam int unsigned HACK_RAM_ADDR_W = 14;
  localparam int unsigned HACK_DATA_W     = 16;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_timer.sv
// Counts cycles the secondary request waits un-granted; flags expiry so the
// next cycle can be forced to the secondary port.
module arb_starve_timer #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dma_valid,
  input  logic dma_ready,
  input  logic force_active,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             waiting;

  // A non-waiting cycle is either an idle/abandoned request or a handshake;
  // both clear the count, as does leaving the forced cycle.
  always_comb begin
    waiting    = dma_valid && !dma_ready;
    count_next = count;
    if (!waiting || force_active)
      count_next = '0;
    else if (count != CNT_MAX)
      count_next = count + 1'b1;
  end

  // Expiry is flagged on the edge where the count reaches the limit, so the
  // forced grant lands in the cycle right after MAX_WAIT waiting cycles.
  assign expired = waiting && !force_active && (count_next == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/hack_ram_arbiter.sv
// Fixed-priority CPU / secondary-master arbiter for the single-port Hack RAM.
// Optional starvation guard: define HACK_ARB_STARVE_GUARD_EN.
module hack_ram_arbiter
  import hack_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = HACK_RAM_ADDR_W,
  parameter int unsigned DATA_W   = HACK_DATA_W,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("hack_ram_arbiter: MAX_WAIT must be at least 1");
  end

  arb_state_e state;
  logic       dma_sel;
  logic       handshake;

  always_comb begin
    dma_sel   = (state == ARB_FORCE) || (!cpu_req && dma_valid);
    dma_ready = dma_sel && dma_valid;
    if (dma_sel) begin
      ram_we    = dma_valid && dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else begin
      ram_we    = cpu_req && cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  assign handshake = dma_valid && dma_ready;
  assign cpu_rdata = ram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= handshake && !dma_we;
      if (handshake && !dma_we)
        dma_rdata <= ram_rdata;
    end
  end

`ifdef HACK_ARB_STARVE_GUARD_EN
  logic expired;

  arb_starve_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .force_active (state == ARB_FORCE),
    .expired      (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_NORMAL;
      cpu_hold <= 1'b0;
    end else begin
      case (state)
        ARB_NORMAL: begin
          state    <= expired ? ARB_FORCE : ARB_NORMAL;
          cpu_hold <= expired;
        end
        default: begin
          state    <= ARB_NORMAL;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end
`else
  assign state    = ARB_NORMAL;
  assign cpu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed self-checking bench for hack_ram_arbiter (guard on or off via
// HACK_ARB_STARVE_GUARD_EN), with a behavioural RAM model attached.
module tb_hack_ram_arbiter;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MAX_WAIT = 8;

  logic              clk;
  logic              reset_n;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;
  logic              dma_valid;
  logic              dma_ready;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  hack_ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_hold   (cpu_hold),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk)
    if (ram_we) mem[ram_addr] <= ram_wdata;

  assign ram_rdata = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    reset_n = 1'b0;
    set_cpu(1'b0, 1'b0, 14'h0000, 16'h0000);
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    tick();
    tick();
    check("rst_cpu_hold",   32'(cpu_hold),   32'h0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check("rst_dma_rdata",  32'(dma_rdata),  32'h0);
    check("rst_dma_ready",  32'(dma_ready),  32'h0);
    check("rst_ram_we",     32'(ram_we),     32'h0);
    reset_n = 1'b1;
    tick();

    // CPU idle: secondary write then read of 0x0100.
    set_dma(1'b1, 1'b1, 14'h0100, 16'h1234);
    #1;
    check("wr_ready",     32'(dma_ready), 32'h1);
    check("wr_ram_we",    32'(ram_we),    32'h1);
    check("wr_ram_addr",  32'(ram_addr),  32'h0100);
    check("wr_ram_wdata", 32'(ram_wdata), 32'h1234);
    tick();
    check("wr_no_rvalid", 32'(dma_rvalid), 32'h0);
    set_dma(1'b1, 1'b0, 14'h0100, 16'h0000);
    #1;
    check("rd_ready",     32'(dma_ready), 32'h1);
    check("rd_ram_we",    32'(ram_we),    32'h0);
    check("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("rd_rvalid", 32'(dma_rvalid), 32'h1);
    check("rd_rdata",  32'(dma_rdata),  32'h1234);
    tick();
    check("rd_rvalid_drop", 32'(dma_rvalid), 32'h0);

    // Back-to-back secondary writes then reads while the CPU is idle.
    set_dma(1'b1, 1'b1, 14'h0200, 16'hAAAA);
    #1 check("b2b_w0_ready", 32'(dma_ready), 32'h1);
    tick();
    set_dma(1'b1, 1'b1, 14'h0201, 16'h5555);
    #1 check("b2b_w1_ready", 32'(dma_ready), 32'h1);
    tick();
    set_dma(1'b1, 1'b0, 14'h0200, 16'h0000);
    #1 check("b2b_r0_ready", 32'(dma_ready), 32'h1);
    tick();
    check("b2b_r0_rvalid", 32'(dma_rvalid), 32'h1);
    check("b2b_r0_rdata",  32'(dma_rdata),  32'hAAAA);
    set_dma(1'b1, 1'b0, 14'h0201, 16'h0000);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("b2b_r1_rvalid", 32'(dma_rvalid), 32'h1);
    check("b2b_r1_rdata",  32'(dma_rdata),  32'h5555);
    tick();

    // CPU and secondary request together: CPU wins, secondary waits.
    set_cpu(1'b1, 1'b0, 14'h0005, 16'h0000);
    set_dma(1'b1, 1'b0, 14'h0100, 16'h0000);
    #1;
    check("prio_ram_addr", 32'(ram_addr),  32'h0005);
    check("prio_ready",    32'(dma_ready), 32'h0);
    tick();
    check("prio_ready_c2", 32'(dma_ready), 32'h0);
    set_cpu(1'b0, 1'b0, 14'h0005, 16'h0000);
    #1;
    check("prio_grant_ready", 32'(dma_ready), 32'h1);
    check("prio_grant_addr",  32'(ram_addr),  32'h0100);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("prio_rvalid", 32'(dma_rvalid), 32'h1);
    check("prio_rdata",  32'(dma_rdata),  32'h1234);
    tick();

    // Reset while a read response is pending drops it asynchronously.
    set_dma(1'b1, 1'b0, 14'h0200, 16'h0000);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("pend_rvalid", 32'(dma_rvalid), 32'h1);
    reset_n = 1'b0;
    #1;
    check("pend_rst_rvalid", 32'(dma_rvalid), 32'h0);
    check("pend_rst_rdata",  32'(dma_rdata),  32'h0);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef HACK_ARB_STARVE_GUARD_EN
    // Continuous CPU load: forced grant after MAX_WAIT waiting cycles.
    set_cpu(1'b1, 1'b0, 14'h0005, 16'h0000);
    set_dma(1'b1, 1'b0, 14'h0100, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("guard_wait_ready_%0d", i), 32'(dma_ready), 32'h0);
      check($sformatf("guard_wait_hold_%0d", i),  32'(cpu_hold),  32'h0);
      tick();
    end
    #1;
    check("guard_force_hold",  32'(cpu_hold),  32'h1);
    check("guard_force_ready", 32'(dma_ready), 32'h1);
    check("guard_force_addr",  32'(ram_addr),  32'h0100);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("guard_after_hold", 32'(cpu_hold),   32'h0);
    check("guard_rvalid",     32'(dma_rvalid), 32'h1);
    check("guard_rdata",      32'(dma_rdata),  32'h1234);
    tick();

    // Forced secondary write wins over a simultaneous CPU write.
    set_cpu(1'b1, 1'b1, 14'h0300, 16'hBEEF);
    set_dma(1'b1, 1'b1, 14'h0300, 16'hC0DE);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("fw_wait_ready_%0d", i), 32'(dma_ready), 32'h0);
      tick();
    end
    #1;
    check("fw_hold",      32'(cpu_hold),  32'h1);
    check("fw_ram_we",    32'(ram_we),    32'h1);
    check("fw_ram_addr",  32'(ram_addr),  32'h0300);
    check("fw_ram_wdata", 32'(ram_wdata), 32'hC0DE);
    tick();
    set_cpu(1'b0, 1'b0, 14'h0000, 16'h0000);
    set_dma(1'b1, 1'b0, 14'h0300, 16'h0000);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("fw_readback_rvalid", 32'(dma_rvalid), 32'h1);
    check("fw_readback_rdata",  32'(dma_rdata),  32'hC0DE);
    tick();

    // Reset asserted in the forced cycle with the read not yet accepted.
    set_cpu(1'b1, 1'b0, 14'h0005, 16'h0000);
    set_dma(1'b1, 1'b0, 14'h0100, 16'h0000);
    for (int i = 0; i < 8; i++) tick();
    #1;
    check("rf_hold_before", 32'(cpu_hold), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rf_hold_async",   32'(cpu_hold),   32'h0);
    check("rf_ready_async",  32'(dma_ready),  32'h0);
    check("rf_rvalid_async", 32'(dma_rvalid), 32'h0);
    tick();
    check("rf_rvalid_dropped", 32'(dma_rvalid), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rf_restart_ready_%0d", i), 32'(dma_ready), 32'h0);
      tick();
    end
    #1;
    check("rf_restart_hold",  32'(cpu_hold),  32'h1);
    check("rf_restart_ready", 32'(dma_ready), 32'h1);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("rf_restart_rvalid", 32'(dma_rvalid), 32'h1);
    check("rf_restart_rdata",  32'(dma_rdata),  32'h1234);
    tick();
`else
    // No guard: the secondary port starves while the CPU stays busy.
    set_cpu(1'b1, 1'b0, 14'h0005, 16'h0000);
    set_dma(1'b1, 1'b0, 14'h0200, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      #1;
      check($sformatf("ng_ready_%0d", i), 32'(dma_ready), 32'h0);
      check($sformatf("ng_hold_%0d", i),  32'(cpu_hold),  32'h0);
      tick();
    end
    set_cpu(1'b0, 1'b0, 14'h0005, 16'h0000);
    #1;
    check("ng_grant_ready", 32'(dma_ready), 32'h1);
    check("ng_grant_addr",  32'(ram_addr),  32'h0200);
    tick();
    set_dma(1'b0, 1'b0, 14'h0000, 16'h0000);
    check("ng_rvalid", 32'(dma_rvalid), 32'h1);
    check("ng_rdata",  32'(dma_rdata),  32'hAAAA);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
